ex_mem_pipe_stage: RTL

Parametrised EX/MEM pipeline stage replacing the fixed-width EX/MEM register. Carries a packed control word and NUM_DATA data lanes from EX to MEM with a valid/ready handshake, a 2-entry skid buffer so stalls do not create combinational ready paths back into EX, and a synchronous flush for branch/exception squash. Sits between the ALU stage and the data-memory stage. Also usable for other stage boundaries by re-parametrising.

---
 rtl/pipe_stage_pkg.sv | 39 +++
 rtl/pipe_stall_counter.sv | 33 +++
 rtl/ex_mem_pipe_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for parametrised pipeline stage registers.
// States, default widths and the field layout of the default EX/MEM control word.
package pipe_stage_pkg;

    // Occupancy state of the two-entry stage (MAIN + SKID)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned NUM_DATA_DEF    = 4;
    localparam int unsigned CTRL_W_DEF      = 12;
    localparam int unsigned STALL_CNT_W_DEF = 16;

    // Default control word: {REG_WRITE_EN, WB_SEL[1:0], READ_WRITE[3:0], rd[4:0]}
    localparam int unsigned RD_LSB    = 0;
    localparam int unsigned RD_W      = 5;
    localparam int unsigned RW_LSB    = 5;
    localparam int unsigned RW_W      = 4;
    localparam int unsigned WBSEL_LSB = 9;
    localparam int unsigned WBSEL_W   = 2;
    localparam int unsigned REGWE_BIT = 11;

    // All-zero control: no register write, no memory access
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    // Entries held in a given state
    function automatic logic [1:0] state_occupancy(input stage_state_e st);
        unique case (st)
            EMPTY:   return 2'd0;
            HALF:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating stall-cycle counter with synchronous active-low reset.
// Only instantiated when EX_MEM_STALL_CNT_EN is defined.
module pipe_stall_counter #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   inc_i,
    output logic [STALL_CNT_W-1:0] count_o
);

    logic [STALL_CNT_W-1:0] count_q, count_d;

    // Increment while requested, holding at all-ones
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {STALL_CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register; only reset clears it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage: control word plus NUM_DATA data lanes behind a
// valid/ready handshake with a 2-entry skid buffer and synchronous flush.
// IN_READY depends only on registered state, so MEM stalls never form a
// combinational path back into EX.
// Optional stall counter enabled by macro EX_MEM_STALL_CNT_EN.
module ex_mem_pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned NUM_DATA    = NUM_DATA_DEF,
    parameter int unsigned CTRL_W      = CTRL_W_DEF,
    parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [CTRL_W-1:0]          IN_CTRL,
    input  logic [NUM_DATA*DATA_W-1:0] IN_DATA,
    input  logic                       FLUSH,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [CTRL_W-1:0]          OUT_CTRL,
    output logic [NUM_DATA*DATA_W-1:0] OUT_DATA,
    output logic [1:0]                 OCCUPANCY
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]     STALL_COUNT
`endif
);

    localparam int unsigned DW = NUM_DATA * DATA_W;

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DW-1:0]     main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;

    logic push;
    logic pop;

    assign IN_READY  = (state_q != FULL);
    assign OUT_VALID = (state_q != EMPTY);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    // Next-state and entry movement; MAIN always holds the oldest entry
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (FLUSH) begin
            // Squash everything; data lanes keep their stale values
            state_d     = EMPTY;
            main_ctrl_d = CTRL_W'(CTRL_BUBBLE);
            skid_ctrl_d = CTRL_W'(CTRL_BUBBLE);
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_ctrl_d = IN_CTRL;
                        main_data_d = IN_DATA;
                        state_d     = HALF;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        main_ctrl_d = IN_CTRL;
                        main_data_d = IN_DATA;
                    end else if (push) begin
                        skid_ctrl_d = IN_CTRL;
                        skid_data_d = IN_DATA;
                        state_d     = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and storage registers; reset beats flush and handshakes
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign OUT_CTRL  = main_ctrl_q;
    assign OUT_DATA  = main_data_q;
    assign OCCUPANCY = state_occupancy(state_q);

`ifdef EX_MEM_STALL_CNT_EN
    pipe_stall_counter #(
        .STALL_CNT_W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .inc_i   (OUT_VALID & ~OUT_READY),
        .count_o (STALL_COUNT)
    );
`endif

endmodule
